// File: rtl/vcortex_fader_if.sv
// Local bus between the fader (master) and the PWM duty RAM (slave).
// Write-only use: the master strobes one cycle, the slave acknowledges later.
interface vcortex_fader_if #(
  parameter int unsigned P_LB_ADDR_W = 12,
  parameter int unsigned P_LB_DATA_W = 16
) ();

  logic                   lb_wr_en_oh;
  logic                   lb_rd_en_oh;
  logic [P_LB_ADDR_W-1:0] lb_addr_od;
  logic [P_LB_DATA_W-1:0] lb_wr_data_od;
  logic                   lb_wr_valid_ih;

  modport master (
    output lb_wr_en_oh,
    output lb_rd_en_oh,
    output lb_addr_od,
    output lb_wr_data_od,
    input  lb_wr_valid_ih
  );

  modport slave (
    input  lb_wr_en_oh,
    input  lb_rd_en_oh,
    input  lb_addr_od,
    input  lb_wr_data_od,
    output lb_wr_valid_ih
  );

endinterface

// File: rtl/vcortex_fader.sv
// Per-channel intensity fader: on each fade tick walks all channels, steps current toward
// target and writes every changed value into the PWM duty RAM over the local bus.
module vcortex_fader #(
  parameter int unsigned                P_NO_CHANNELS  = 16,
  parameter int unsigned                P_LB_ADDR_W    = 12,
  parameter int unsigned                P_LB_DATA_W    = 16,
  parameter logic [P_LB_ADDR_W-1:0]     P_PWM_RAM_BASE = 12'h010,
  parameter logic [15:0]                P_DIV_DEFAULT  = 16'd50000,
  parameter int unsigned                P_TIMEOUT      = 64
) (
  input  logic                  clk_ir,
  input  logic                  rst_il,
  input  logic                  cfg_wr_en_ih,
  input  logic [4:0]            cfg_addr_id,
  input  logic [15:0]           cfg_wr_data_id,
  vcortex_fader_if.master       lb,
  output logic                  busy_oh,
  output logic                  timeout_err_oh,
  output logic                  overrun_oh
);

  localparam int unsigned ChW = (P_NO_CHANNELS > 1) ? $clog2(P_NO_CHANNELS) : 1;
  localparam int unsigned ToW = $clog2(P_TIMEOUT + 1);

  localparam logic [4:0] AddrStep = 5'd16;
  localparam logic [4:0] AddrDiv  = 5'd17;
  localparam logic [4:0] AddrCtrl = 5'd18;

  typedef logic [P_LB_DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StWrite,
    StWait
  } state_e;

  // Configuration registers
  data_t       target_q [P_NO_CHANNELS];
  data_t       step_q;
  logic [15:0] div_q;
  logic        enable_q;

  // Walk state
  data_t          current_q [P_NO_CHANNELS];
  state_e         state_q, state_d;
  logic [ChW-1:0] ch_q, ch_d;
  logic [ToW-1:0] wait_cnt_q, wait_cnt_d;

  // Tick and flags
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic        pending_q, pending_d;
  logic        terr_q, terr_d;
  logic        ovr_q, ovr_d;

  logic        cfg_target, cfg_step, cfg_div, cfg_ctrl, clr_flags;
  logic [15:0] div_eff;
  logic        tick, pend_take, overrun_set, timeout_set, next_ch;
  logic        cur_we, up;
  data_t       cur_ch, tgt_ch, diff, cur_new;

  // ---------------------------------------------------------------------------
  // Configuration port
  // ---------------------------------------------------------------------------
  assign cfg_target = cfg_wr_en_ih && (32'(cfg_addr_id) < P_NO_CHANNELS);
  assign cfg_step   = cfg_wr_en_ih && (cfg_addr_id == AddrStep);
  assign cfg_div    = cfg_wr_en_ih && (cfg_addr_id == AddrDiv);
  assign cfg_ctrl   = cfg_wr_en_ih && (cfg_addr_id == AddrCtrl);
  assign clr_flags  = cfg_ctrl && cfg_wr_data_id[1];

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      target_q <= '{default: '0};
      step_q   <= P_LB_DATA_W'(1);
      div_q    <= P_DIV_DEFAULT;
      enable_q <= 1'b0;
    end else begin
      if (cfg_target) target_q[cfg_addr_id[ChW-1:0]] <= P_LB_DATA_W'(cfg_wr_data_id);
      if (cfg_step)   step_q   <= P_LB_DATA_W'(cfg_wr_data_id);
      if (cfg_div)    div_q    <= cfg_wr_data_id;
      if (cfg_ctrl)   enable_q <= cfg_wr_data_id[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Fade tick generator and pending-tick bookkeeping
  // ---------------------------------------------------------------------------
  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
  // >= rather than == so a shrinking divider cannot strand the counter above its wrap point
  assign tick    = enable_q && (tick_cnt_q >= (div_eff - 16'd1));

  assign pend_take   = (state_q == StIdle) && pending_q;
  assign overrun_set = tick && pending_q && !pend_take;

  always_comb begin
    tick_cnt_d = tick_cnt_q + 16'd1;
    if (!enable_q || tick) tick_cnt_d = 16'd0;

    pending_d = pending_q;
    if (!enable_q)      pending_d = 1'b0;
    else if (tick)      pending_d = 1'b1;
    else if (pend_take) pending_d = 1'b0;

    ovr_d = ovr_q;
    if (clr_flags)   ovr_d = 1'b0;
    if (overrun_set) ovr_d = 1'b1;

    terr_d = terr_q;
    if (clr_flags)   terr_d = 1'b0;
    if (timeout_set) terr_d = 1'b1;
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      tick_cnt_q <= 16'd0;
      pending_q  <= 1'b0;
      ovr_q      <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pending_q  <= pending_d;
      ovr_q      <= ovr_d;
      terr_q     <= terr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Ramp arithmetic for the channel under evaluation
  // ---------------------------------------------------------------------------
  assign cur_ch = current_q[ch_q];
  assign tgt_ch = target_q[ch_q];
  assign up     = tgt_ch > cur_ch;
  assign diff   = up ? (tgt_ch - cur_ch) : (cur_ch - tgt_ch);

  always_comb begin
    cur_new = tgt_ch;
    // diff > step guarantees the +/- below cannot wrap
    if (step_q != '0 && diff > step_q) begin
      cur_new = up ? (cur_ch + step_q) : (cur_ch - step_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Channel walk FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    wait_cnt_d  = wait_cnt_q;
    cur_we      = 1'b0;
    timeout_set = 1'b0;
    next_ch     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          ch_d    = '0;
          state_d = StEval;
        end
      end
      StEval: begin
        if (cur_ch == tgt_ch) begin
          next_ch = 1'b1;
        end else begin
          cur_we  = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (lb.lb_wr_valid_ih) begin
          next_ch = 1'b1;
        end else if (wait_cnt_q == ToW'(P_TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          next_ch     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + ToW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (next_ch) begin
      if (ch_q == ChW'(P_NO_CHANNELS - 1)) begin
        state_d = StIdle;
      end else begin
        ch_d    = ch_q + ChW'(1);
        state_d = StEval;
      end
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      current_q <= '{default: '0};
    end else if (cur_we) begin
      current_q[ch_q] <= cur_new;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state so reset clears them without a clock
  // ---------------------------------------------------------------------------
  assign lb.lb_wr_en_oh   = (state_q == StWrite);
  assign lb.lb_rd_en_oh   = 1'b0;
  assign lb.lb_addr_od    = (state_q == StWrite) ? (P_PWM_RAM_BASE + P_LB_ADDR_W'(ch_q)) : '0;
  assign lb.lb_wr_data_od = (state_q == StWrite) ? cur_ch : '0;

  assign busy_oh        = (state_q != StIdle);
  assign timeout_err_oh = terr_q;
  assign overrun_oh     = ovr_q;

endmodule

// File: tb/tb_vcortex_fader.sv
// Directed bench for vcortex_fader: a table of config-then-walk vectors plus hand-written
// sequences for timeout, overrun and mid-walk reset.
module tb_vcortex_fader;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        busy, terr, ovr;

  always #5 clk = ~clk;

  vcortex_fader_if #(.P_LB_ADDR_W(AW), .P_LB_DATA_W(DW)) lb ();

  vcortex_fader #(
    .P_NO_CHANNELS (N),
    .P_LB_ADDR_W   (AW),
    .P_LB_DATA_W   (DW),
    .P_PWM_RAM_BASE(12'h010),
    .P_DIV_DEFAULT (16'd50000),
    .P_TIMEOUT     (64)
  ) dut (
    .clk_ir        (clk),
    .rst_il        (rst_n),
    .cfg_wr_en_ih  (cfg_wr_en),
    .cfg_addr_id   (cfg_addr),
    .cfg_wr_data_id(cfg_data),
    .lb            (lb.master),
    .busy_oh       (busy),
    .timeout_err_oh(terr),
    .overrun_oh    (ovr)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Slave model: logs every strobe and acks ack_delay cycles later (0 = never)
  logic [11:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          ack_delay = 1;
  int          ack_cd = 0;

  initial begin
    lb.lb_wr_valid_ih = 1'b0;
    forever begin
      @(negedge clk);
      if (lb.lb_wr_en_oh === 1'b1) begin
        wa_q.push_back(lb.lb_addr_od);
        wd_q.push_back(lb.lb_wr_data_od);
        ack_cd = ack_delay;
      end
      @(posedge clk);
      #1;
      lb.lb_wr_valid_ih = 1'b0;
      if (ack_cd > 0) begin
        ack_cd--;
        if (ack_cd == 0) lb.lb_wr_valid_ih = 1'b1;
      end
    end
  end

  typedef struct {
    logic [4:0]  a0;
    logic [15:0] d0;
    logic [4:0]  a1;
    logic [15:0] d1;
    int          n;
    logic [11:0] ea0;
    logic [15:0] ed0;
    logic [11:0] ea1;
    logic [15:0] ed1;
  } vec_t;

  localparam int NV = 13;
  vec_t vt[NV];

  function automatic vec_t mk(input logic [4:0] a0, input logic [15:0] d0,
                              input logic [4:0] a1, input logic [15:0] d1, input int n,
                              input logic [11:0] ea0, input logic [15:0] ed0,
                              input logic [11:0] ea1, input logic [15:0] ed1);
    vec_t v;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.n = n;
    v.ea0 = ea0; v.ed0 = ed0; v.ea1 = ea1; v.ed1 = ed1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg_wr(input logic [4:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic wait_walk(output bit ok);
    int c;
    ok = 1'b1;
    c  = 0;
    while (busy !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (busy !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    c = 0;
    while (busy === 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (busy === 1'b1) ok = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy === 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_strobe(output bit ok);
    int c = 0;
    while (lb.lb_wr_en_oh !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    ok = (lb.lb_wr_en_oh === 1'b1);
  endtask

  initial begin
    bit ok;
    int c;

    // Walk vectors; address 31 is an unused config slot and acts as a no-op write
    vt[0]  = mk(5'd16, 16'h0100, 5'd3,  16'h0300, 1, 12'h013, 16'h0100, 12'h000, 16'h0000);
    vt[1]  = mk(5'd31, 16'h0000, 5'd31, 16'h0000, 1, 12'h013, 16'h0200, 12'h000, 16'h0000);
    vt[2]  = mk(5'd31, 16'h0000, 5'd31, 16'h0000, 1, 12'h013, 16'h0300, 12'h000, 16'h0000);
    vt[3]  = mk(5'd31, 16'h0000, 5'd31, 16'h0000, 0, 12'h000, 16'h0000, 12'h000, 16'h0000);
    vt[4]  = mk(5'd16, 16'h0000, 5'd5,  16'h0080, 1, 12'h015, 16'h0080, 12'h000, 16'h0000);
    vt[5]  = mk(5'd16, 16'h0050, 5'd5,  16'h0010, 1, 12'h015, 16'h0030, 12'h000, 16'h0000);
    vt[6]  = mk(5'd31, 16'h0000, 5'd31, 16'h0000, 1, 12'h015, 16'h0010, 12'h000, 16'h0000);
    vt[7]  = mk(5'd31, 16'h0000, 5'd31, 16'h0000, 0, 12'h000, 16'h0000, 12'h000, 16'h0000);
    vt[8]  = mk(5'd16, 16'h0000, 5'd15, 16'hFFFF, 1, 12'h01F, 16'hFFFF, 12'h000, 16'h0000);
    vt[9]  = mk(5'd31, 16'h0000, 5'd31, 16'h0000, 0, 12'h000, 16'h0000, 12'h000, 16'h0000);
    vt[10] = mk(5'd1,  16'h0005, 5'd2,  16'h0030, 2, 12'h011, 16'h0005, 12'h012, 16'h0030);
    vt[11] = mk(5'd16, 16'h0010, 5'd2,  16'h0000, 1, 12'h012, 16'h0020, 12'h000, 16'h0000);
    vt[12] = mk(5'd16, 16'h0020, 5'd31, 16'h0000, 1, 12'h012, 16'h0000, 12'h000, 16'h0000);

    // Reset state
    #12;
    check("rst_wr_en", 32'(lb.lb_wr_en_oh), 32'd0);
    check("rst_rd_en", 32'(lb.lb_rd_en_oh), 32'd0);
    check("rst_addr",  32'(lb.lb_addr_od), 32'd0);
    check("rst_data",  32'(lb.lb_wr_data_od), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_terr",  32'(terr), 32'd0);
    check("rst_ovr",   32'(ovr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cfg_wr(5'd17, 16'd100);
    cfg_wr(5'd18, 16'h0001);

    for (int i = 0; i < NV; i++) begin
      cfg_wr(vt[i].a0, vt[i].d0);
      cfg_wr(vt[i].a1, vt[i].d1);
      wa_q.delete();
      wd_q.delete();
      wait_walk(ok);
      check($sformatf("v%0d_walk_done", i), 32'(ok), 32'd1);
      check($sformatf("v%0d_nwrites", i), 32'(wa_q.size()), 32'(vt[i].n));
      if (vt[i].n > 0 && wa_q.size() > 0) begin
        check($sformatf("v%0d_addr0", i), 32'(wa_q[0]), 32'(vt[i].ea0));
        check($sformatf("v%0d_data0", i), 32'(wd_q[0]), 32'(vt[i].ed0));
      end
      if (vt[i].n > 1 && wa_q.size() > 1) begin
        check($sformatf("v%0d_addr1", i), 32'(wa_q[1]), 32'(vt[i].ea1));
        check($sformatf("v%0d_data1", i), 32'(wd_q[1]), 32'(vt[i].ed1));
      end
      check($sformatf("v%0d_ovr", i), 32'(ovr), 32'd0);
    end

    // Slave never acks: one strobe, timeout 64 WAIT cycles later, walk still completes
    ack_delay = 0;
    cfg_wr(5'd16, 16'h0000);
    cfg_wr(5'd0, 16'h0001);
    wa_q.delete();
    wd_q.delete();
    wait_strobe(ok);
    check("to_strobe_seen", 32'(ok), 32'd1);
    check("to_terr_before", 32'(terr), 32'd0);
    c = 0;
    while (terr !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("to_latency", 32'(c), 32'd65);
    check("to_busy_after", 32'(busy), 32'd1);
    wait_idle("to_walk_end");
    check("to_terr_sticky", 32'(terr), 32'd1);
    check("to_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() > 0) begin
      check("to_addr", 32'(wa_q[0]), 32'h010);
      check("to_data", 32'(wd_q[0]), 32'h0001);
    end
    cfg_wr(5'd18, 16'h0003);
    @(negedge clk);
    check("to_terr_cleared", 32'(terr), 32'd0);

    // divider=1, all channels changing, slow slave: overrun while busy, writes in order
    ack_delay = 3;
    cfg_wr(5'd18, 16'h0000);
    wait_idle("ov_idle_pre");
    for (int n = 0; n < 16; n++) cfg_wr(5'(n), 16'h0100 + 16'(n));
    cfg_wr(5'd17, 16'd1);
    wa_q.delete();
    wd_q.delete();
    cfg_wr(5'd18, 16'h0001);
    c = 0;
    while (wa_q.size() < 16 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("ov_nwrites", 32'(wa_q.size()), 32'd16);
    check("ov_overrun", 32'(ovr), 32'd1);
    check("ov_busy", 32'(busy), 32'd1);
    for (int n = 0; n < 16 && n < wa_q.size(); n++) begin
      check($sformatf("ov_addr%0d", n), 32'(wa_q[n]), 32'h010 + 32'(n));
      check($sformatf("ov_data%0d", n), 32'(wd_q[n]), 32'h0100 + 32'(n));
    end
    cfg_wr(5'd18, 16'h0000);
    wait_idle("ov_idle_post");
    check("ov_terr", 32'(terr), 32'd0);

    // Reset asserted in WAIT: outputs clear at once, registers return to reset values
    ack_delay = 0;
    cfg_wr(5'd17, 16'd100);
    cfg_wr(5'd7, 16'h1234);
    cfg_wr(5'd18, 16'h0001);
    wait_strobe(ok);
    check("rs_strobe_seen", 32'(ok), 32'd1);
    check("rs_strobe_addr", 32'(lb.lb_addr_od), 32'h017);
    @(negedge clk);
    check("rs_ovr_pre", 32'(ovr), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_busy",  32'(busy), 32'd0);
    check("rs_wr_en", 32'(lb.lb_wr_en_oh), 32'd0);
    check("rs_addr",  32'(lb.lb_addr_od), 32'd0);
    check("rs_data",  32'(lb.lb_wr_data_od), 32'd0);
    check("rs_ovr",   32'(ovr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_delay = 1;
    cfg_wr(5'd17, 16'd100);
    cfg_wr(5'd4, 16'h0003);
    cfg_wr(5'd18, 16'h0001);
    // Reset step is 1 and every current/target is 0, so only channel 4 moves, by 1 per walk
    for (int w = 1; w <= 3; w++) begin
      wa_q.delete();
      wd_q.delete();
      wait_walk(ok);
      check($sformatf("rs_walk%0d_done", w), 32'(ok), 32'd1);
      check($sformatf("rs_walk%0d_nwrites", w), 32'(wa_q.size()), 32'd1);
      if (wa_q.size() > 0) begin
        check($sformatf("rs_walk%0d_addr", w), 32'(wa_q[0]), 32'h014);
        check($sformatf("rs_walk%0d_data", w), 32'(wd_q[0]), 32'(w));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vcortex_fader.md
# vcortex_fader

Local-bus master upstream of the visual cortex top level. It holds a per-channel target intensity and a current intensity, and ramps each current value toward its target by a programmable step on every fade tick. Each changed value is written into the PWM duty RAM over the vcortex local bus, so LED channels fade smoothly without CPU traffic per step.

## Interface
- P_NO_CHANNELS, 16, number of PWM channels (power of 2)
- P_LB_ADDR_W, 12, local bus address width
- P_LB_DATA_W, 16, local bus data width, which is also the intensity width
- P_PWM_RAM_BASE, 12'h010, local bus address of channel 0 duty word; channel n is at base+n
- P_DIV_DEFAULT, 16'd50000, reset value of the tick divider
- P_TIMEOUT, 64, cycles to wait for lb_wr_valid_ih before abandoning a write

Ports:
- clk_ir  in  1  clock
- rst_il  in  1  asynchronous active-low reset
- cfg_wr_en_ih  in  1  config write strobe
- cfg_addr_id  in  5  config address: 0..15 target[n], 16 step, 17 divider, 18 control (bit0 enable, bit1 clear flags)
- cfg_wr_data_id  in  16  config write data
- lb_wr_en_oh  out  1  local bus write strobe, one cycle wide
- lb_rd_en_oh  out  1  tied 0
- lb_addr_od  out  P_LB_ADDR_W  local bus address
- lb_wr_data_od  out  P_LB_DATA_W  local bus write data
- lb_wr_valid_ih  in  1  slave write acknowledge
- busy_oh  out  1  1 while a channel walk is in progress
- timeout_err_oh  out  1  sticky: a write was not acknowledged in time
- overrun_oh  out  1  sticky: a tick arrived while one was already pending

## Operation
- Registers reset to: target[] and current[] = 0, step = 1, divider = P_DIV_DEFAULT, enable = 0, flags = 0.
- Tick counter:
  - Counts 0..divider-1 while enable=1, and asserts tick on the cycle it wraps to 0.
  - The counter is held at 0 while enable=0.
  - A divider value of 0 is treated as 1, which gives a tick every cycle.
- Pending tick handling:
  - A tick sets `pending`.
  - If `pending` is already set, overrun_oh sets and the extra tick is dropped.
- FSM states: IDLE, EVAL, WRITE, WAIT.
  - IDLE: if `pending`, clear it, set ch=0, go to EVAL.
  - EVAL:
    - If current[ch]==target[ch], skip the write and go to the next channel.
    - Otherwise compute new = target if |target-current| <= step, else current±step (unsigned 16-bit, no wrap).
    - step=0 means jump directly to target.
    - Latch new into current[ch] and go to WRITE.
  - WRITE: drive lb_wr_en_oh=1, lb_addr_od=P_PWM_RAM_BASE+ch, lb_wr_data_od=current[ch] for one cycle, then go to WAIT.
  - WAIT:
    - On lb_wr_valid_ih, go to the next channel.
    - After P_TIMEOUT cycles without an acknowledge, set timeout_err_oh and go to the next channel.
    - The current value stays updated after a timeout; the write is not retried.
  - Next channel: if ch==P_NO_CHANNELS-1, go to IDLE; else ch+1 and go to EVAL.
- busy_oh = (state != IDLE).
- Config writes take effect on the next cycle.
  - A target write to the channel under evaluation is used on that channel's next visit.
  - Step and divider changes apply immediately.
- Clearing enable:
  - Stops ticks and clears `pending`.
  - An in-progress walk completes.
- Control bit1 clears timeout_err_oh and overrun_oh. If a set event occurs in the same cycle, the set wins.

## Timing
- During reset and in IDLE, all outputs are 0. Address and data outputs read 0 when not in WRITE.
- Tick to first lb_wr_en_oh: 3 cycles (tick→pending, IDLE→EVAL, EVAL→WRITE).
- Per written channel: 2 cycles plus acknowledge latency. A skipped channel costs 1 cycle.
- lb_wr_valid_ih is only honoured in WAIT. It is ignored in any other state, including the same cycle as lb_wr_en_oh.
- Asynchronous reset mid-walk aborts immediately. lb_wr_en_oh drops without waiting for a clock edge.

## Test plan
- Reset, enable=1, divider=4, step=0x100, target[3]=0x0300, slave acks 1 cycle after strobe.
  - Expect exactly three writes to addr 0x013 with data 0x0100, 0x0200, 0x0300, one per walk.
  - Expect no writes to any other channel.
- current[5]=0x0080, target[5]=0x0010, step=0x0050.
  - Expect writes 0x0030, then 0x0010, then no further writes.
- step=0, target[15]=0xFFFF.
  - Expect a single write of 0xFFFF to addr 0x01F on the first walk.
- Slave never acks, target[0]=1.
  - Expect lb_wr_en_oh once, then timeout_err_oh=1 after 64 WAIT cycles, then walk completion.
  - Control bit1 write clears the flag.
- divider=1 with all channels changing and a slow slave.
  - Expect overrun_oh=1 while busy_oh stays 1.
  - Writes still go out in channel order 0..15.
- Assert rst_il low during WAIT.
  - Expect all outputs 0 immediately, and current[]/target[] back to 0 after release.
